// File: rtl/rggen_register_initiator_pkg.sv
// rggen_register_initiator_pkg
// Shared definitions for the register-bus initiator.
// Contents:
//   state_e         initiator FSM states (IDLE / BUSY / RESPONSE)
//   STATUS_*        host response status codes
//   counter_width   width of the BUSY-cycle timeout counter (never below 1)
package rggen_register_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    RESPONSE = 2'd2
  } state_e;

  localparam logic [1:0] STATUS_OKAY    = 2'b00;
  localparam logic [1:0] STATUS_SLVERR  = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

  // The counter only has to reach cycles-1. A disabled timeout (0) or a
  // one-cycle timeout still gets a 1-bit counter, so the vector is never empty.
  function automatic int counter_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/rggen_register_initiator_mux.sv
// rggen_register_initiator_mux
// One-hot OR multiplexer. It collects a field from whichever register
// responders are selected.
// Ports:
//   select  in  ENTRIES        one bit per entry
//   data    in  WIDTH*ENTRIES  entry n at [WIDTH*n+:WIDTH]
//   result  out WIDTH          OR of all selected entries
module rggen_register_initiator_mux #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 1
) (
  input  logic [ENTRIES-1:0]       select,
  input  logic [WIDTH*ENTRIES-1:0] data,
  output logic [WIDTH-1:0]         result
);

  // Several selected entries produce the OR of their data. That case is a
  // system error upstream, so the result is not resolved here.
  always_comb begin
    result = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (select[i]) begin
        result = result | data[WIDTH*i+:WIDTH];
      end
    end
  end

endmodule

// File: rtl/rggen_register_initiator.sv
// rggen_register_initiator
// Host-side initiator for the register request/response bus. It accepts one
// host request, holds it on the register bus until a responder finishes,
// and returns status and read data. Only one transaction is outstanding.
// The initiator flags requests that no register decodes, and an optional
// timeout releases it from a hung responder.
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_host_*  / o_host_*       host request (valid/ready) and response (valid/ready)
//   o_register_*               latched request driven to the register responders
//   i_register_*               per-responder active/ready/status/read data
module rggen_register_initiator
  import rggen_register_initiator_pkg::*;
#(
  parameter int   ADDRESS_WIDTH  = 8,
  parameter int   BUS_WIDTH      = 32,
  parameter int   REGISTERS      = 1,
  parameter logic ERROR_STATUS   = 1'b0,
  parameter int   TIMEOUT_CYCLES = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_host_valid,
  output logic                           o_host_ready,
  input  logic [1:0]                     i_host_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_host_address,
  input  logic [BUS_WIDTH-1:0]           i_host_write_data,
  input  logic [BUS_WIDTH-1:0]           i_host_strobe,
  output logic                           o_host_resp_valid,
  input  logic                           i_host_resp_ready,
  output logic [1:0]                     o_host_status,
  output logic [BUS_WIDTH-1:0]           o_host_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH-1:0]           o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  localparam int COUNTER_WIDTH = counter_width(TIMEOUT_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST =
    COUNTER_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_ENABLE = (TIMEOUT_CYCLES != 0);

  state_e                   state;
  logic [COUNTER_WIDTH-1:0] counter;
  logic                     active;
  logic                     done;
  logic [1:0]               mux_status;
  logic [BUS_WIDTH-1:0]     mux_read_data;
  logic                     exit_busy;
  logic [1:0]               exit_status;
  logic [BUS_WIDTH-1:0]     exit_data;

  assign active = |i_register_active;
  assign done   = |(i_register_active & i_register_ready);

  rggen_register_initiator_mux #(
    .WIDTH   (BUS_WIDTH),
    .ENTRIES (REGISTERS)
  ) u_read_data_mux (
    .select (i_register_active),
    .data   (i_register_read_data),
    .result (mux_read_data)
  );

  rggen_register_initiator_mux #(
    .WIDTH   (2),
    .ENTRIES (REGISTERS)
  ) u_status_mux (
    .select (i_register_active),
    .data   (i_register_status),
    .result (mux_status)
  );

  // Decide whether BUSY ends this cycle, and with which result.
  // Priority: no decode > responder done > timeout.
  // Read data reaches the host only for a successful read.
  always_comb begin
    exit_busy   = 1'b1;
    exit_status = STATUS_OKAY;
    exit_data   = '0;
    if (!active) begin
      exit_status = {ERROR_STATUS, 1'b0};
    end else if (done) begin
      exit_status = mux_status;
      if (!o_register_access[0] && (mux_status == STATUS_OKAY)) begin
        exit_data = mux_read_data;
      end
    end else if (TIMEOUT_ENABLE && (counter == TIMEOUT_LAST)) begin
      exit_status = STATUS_TIMEOUT;
    end else begin
      exit_busy = 1'b0;
    end
  end

  // FSM. All host and register-bus handshake outputs are registered here.
  // o_host_ready is 1 only in IDLE, so a response that is consumed in a
  // cycle can never overlap the acceptance of the next request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                 <= IDLE;
      counter               <= '0;
      o_host_ready          <= 1'b1;
      o_host_resp_valid     <= 1'b0;
      o_host_status         <= STATUS_OKAY;
      o_host_read_data      <= '0;
      o_register_valid      <= 1'b0;
      o_register_access     <= '0;
      o_register_address    <= '0;
      o_register_write_data <= '0;
      o_register_strobe     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_host_valid) begin
            o_register_access     <= i_host_access;
            o_register_address    <= i_host_address;
            o_register_write_data <= i_host_write_data;
            o_register_strobe     <= i_host_strobe;
            o_host_ready          <= 1'b0;
            o_register_valid      <= 1'b1;
            state                 <= BUSY;
          end
        end
        BUSY: begin
          if (exit_busy) begin
            o_register_valid  <= 1'b0;
            o_host_resp_valid <= 1'b1;
            o_host_status     <= exit_status;
            o_host_read_data  <= exit_data;
            counter           <= '0;
            state             <= RESPONSE;
          end else begin
            counter <= counter + COUNTER_WIDTH'(1);
          end
        end
        RESPONSE: begin
          if (i_host_resp_ready) begin
            o_host_resp_valid <= 1'b0;
            o_host_status     <= STATUS_OKAY;
            o_host_read_data  <= '0;
            o_host_ready      <= 1'b1;
            state             <= IDLE;
          end
        end
        default: begin
          o_host_ready      <= 1'b1;
          o_host_resp_valid <= 1'b0;
          o_register_valid  <= 1'b0;
          counter           <= '0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_register_initiator.sv
// tb_rggen_register_initiator
// Directed testbench for rggen_register_initiator.
// Instance a: REGISTERS=2, ERROR_STATUS=1, TIMEOUT_CYCLES=4.
// Instance b: REGISTERS=1, ERROR_STATUS=0, timeout disabled. Instance b only
// shows how an undecoded request is reported when ERROR_STATUS is 0.
module tb_rggen_register_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_valid = 1'b0;
  logic [1:0]  host_access = '0;
  logic [7:0]  host_address = '0;
  logic [31:0] host_write_data = '0;
  logic [31:0] host_strobe = '0;
  logic        host_resp_ready = 1'b0;

  logic        a_host_ready, a_resp_valid, a_register_valid;
  logic [1:0]  a_status, a_register_access;
  logic [31:0] a_read_data, a_register_write_data, a_register_strobe;
  logic [7:0]  a_register_address;
  logic [1:0]  a_active = '0;
  logic [1:0]  a_ready = '0;
  logic [3:0]  a_reg_status = '0;
  logic [63:0] a_reg_read_data = '0;

  logic        b_valid = 1'b0;
  logic        b_resp_ready = 1'b0;
  logic        b_host_ready, b_resp_valid, b_register_valid;
  logic [1:0]  b_status, b_register_access;
  logic [31:0] b_read_data, b_register_write_data, b_register_strobe;
  logic [7:0]  b_register_address;
  logic [0:0]  b_active = 1'b0;
  logic [0:0]  b_ready = 1'b1;
  logic [1:0]  b_reg_status = 2'b10;
  logic [31:0] b_reg_read_data = 32'hFFFF_FFFF;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  rggen_register_initiator #(
    .ADDRESS_WIDTH (8), .BUS_WIDTH (32), .REGISTERS (2),
    .ERROR_STATUS (1'b1), .TIMEOUT_CYCLES (4)
  ) dut_a (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_host_valid (host_valid), .o_host_ready (a_host_ready),
    .i_host_access (host_access), .i_host_address (host_address),
    .i_host_write_data (host_write_data), .i_host_strobe (host_strobe),
    .o_host_resp_valid (a_resp_valid), .i_host_resp_ready (host_resp_ready),
    .o_host_status (a_status), .o_host_read_data (a_read_data),
    .o_register_valid (a_register_valid), .o_register_access (a_register_access),
    .o_register_address (a_register_address),
    .o_register_write_data (a_register_write_data),
    .o_register_strobe (a_register_strobe),
    .i_register_active (a_active), .i_register_ready (a_ready),
    .i_register_status (a_reg_status), .i_register_read_data (a_reg_read_data)
  );

  rggen_register_initiator #(
    .ADDRESS_WIDTH (8), .BUS_WIDTH (32), .REGISTERS (1),
    .ERROR_STATUS (1'b0), .TIMEOUT_CYCLES (0)
  ) dut_b (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_host_valid (b_valid), .o_host_ready (b_host_ready),
    .i_host_access (host_access), .i_host_address (host_address),
    .i_host_write_data (host_write_data), .i_host_strobe (host_strobe),
    .o_host_resp_valid (b_resp_valid), .i_host_resp_ready (b_resp_ready),
    .o_host_status (b_status), .o_host_read_data (b_read_data),
    .o_register_valid (b_register_valid), .o_register_access (b_register_access),
    .o_register_address (b_register_address),
    .o_register_write_data (b_register_write_data),
    .o_register_strobe (b_register_strobe),
    .i_register_active (b_active), .i_register_ready (b_ready),
    .i_register_status (b_reg_status), .i_register_read_data (b_reg_read_data)
  );

  // Wait for a rising edge, then move 1 ns past it so that sampling and
  // driving never race the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request to instance a for one cycle. On return the request
  // has been accepted, and this is the first BUSY cycle.
  task automatic start_request(input logic [1:0] acc, input logic [7:0] addr,
                               input logic [31:0] wd, input logic [31:0] st);
    host_valid      = 1'b1;
    host_access     = acc;
    host_address    = addr;
    host_write_data = wd;
    host_strobe     = st;
    tick();
    host_valid = 1'b0;
  endtask

  task automatic consume_response();
    host_resp_ready = 1'b1;
    tick();
    host_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_compared++;
    if ({a_host_ready, a_resp_valid, a_register_valid} !== 3'b100) begin
      $display("[TB] FAIL reset_handshake: got %b expected 100",
               {a_host_ready, a_resp_valid, a_register_valid});
      n_mismatched++;
    end
    n_compared++;
    if ({a_status, a_read_data, a_register_address, a_register_strobe} !== 74'd0) begin
      $display("[TB] FAIL reset_values: status=%b data=%h addr=%h strobe=%h expected all zero",
               a_status, a_read_data, a_register_address, a_register_strobe);
      n_mismatched++;
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    // reg1 answers at once. reg0 carries other values, which must not reach the host.
    a_active = 2'b10; a_ready = 2'b10;
    a_reg_status = 4'b00_10; a_reg_read_data = {32'hA5A5_0001, 32'hDEAD_BEEF};
    start_request(2'b00, 8'h10, 32'h0, 32'h0);
    n_compared++;
    if ({a_register_valid, a_host_ready, a_resp_valid} !== 3'b100) begin
      $display("[TB] FAIL read_busy: got %b expected 100",
               {a_register_valid, a_host_ready, a_resp_valid});
      n_mismatched++;
    end
    tick();
    n_compared++;
    if ({a_resp_valid, a_register_valid, a_status, a_read_data} !== {1'b1, 1'b0, 2'b00, 32'hA5A5_0001}) begin
      $display("[TB] FAIL read_response: valid=%b regvalid=%b status=%b data=%h expected 1 0 00 a5a50001",
               a_resp_valid, a_register_valid, a_status, a_read_data);
      n_mismatched++;
    end
    consume_response();
    n_compared++;
    if ({a_resp_valid, a_host_ready} !== 2'b01) begin
      $display("[TB] FAIL read_release: got %b expected 01", {a_resp_valid, a_host_ready});
      n_mismatched++;
    end
    // A responder that reports SLVERR gets its read data forced to zero.
    a_reg_status = 4'b10_00; a_reg_read_data = {32'h0000_1234, 32'h0};
    start_request(2'b00, 8'h14, 32'h0, 32'h0);
    tick();
    n_compared++;
    if ({a_resp_valid, a_status, a_read_data} !== {1'b1, 2'b10, 32'h0}) begin
      $display("[TB] FAIL read_slverr: valid=%b status=%b data=%h expected 1 10 00000000",
               a_resp_valid, a_status, a_read_data);
      n_mismatched++;
    end
    consume_response();
  endtask

  task automatic test_write();
    // reg0 is not ready for three cycles and becomes ready in the fourth.
    // The counter has then reached the timeout value, so this also checks
    // that a completing responder wins over the timeout.
    a_active = 2'b01; a_ready = 2'b00;
    a_reg_status = 4'b00_00; a_reg_read_data = {32'h0, 32'hFFFF_FFFF};
    start_request(2'b01, 8'h04, 32'hCAFE_1234, 32'h0000_FFFF);
    for (int k = 1; k <= 4; k++) begin
      n_compared++;
      if ({a_register_valid, a_resp_valid} !== 2'b10) begin
        $display("[TB] FAIL write_valid_%0d: got %b expected 10", k, {a_register_valid, a_resp_valid});
        n_mismatched++;
      end
      n_compared++;
      if ({a_register_access, a_register_address, a_register_write_data, a_register_strobe}
          !== {2'b01, 8'h04, 32'hCAFE_1234, 32'h0000_FFFF}) begin
        $display("[TB] FAIL write_fields_%0d: acc=%b addr=%h wd=%h st=%h expected 01 04 cafe1234 0000ffff",
                 k, a_register_access, a_register_address, a_register_write_data, a_register_strobe);
        n_mismatched++;
      end
      if (k == 4) a_ready = 2'b01;
      tick();
    end
    n_compared++;
    if ({a_resp_valid, a_register_valid, a_status, a_read_data} !== {1'b1, 1'b0, 2'b00, 32'h0}) begin
      $display("[TB] FAIL write_response: valid=%b regvalid=%b status=%b data=%h expected 1 0 00 00000000",
               a_resp_valid, a_register_valid, a_status, a_read_data);
      n_mismatched++;
    end
    consume_response();
    a_ready = 2'b00;
  endtask

  task automatic test_no_match();
    a_active = 2'b00; a_ready = 2'b11; a_reg_read_data = {32'h1111_1111, 32'h2222_2222};
    start_request(2'b00, 8'h80, 32'h0, 32'h0);
    n_compared++;
    if (a_register_valid !== 1'b1) begin
      $display("[TB] FAIL nomatch_busy: got %b expected 1", a_register_valid);
      n_mismatched++;
    end
    tick();
    n_compared++;
    if ({a_resp_valid, a_status, a_read_data} !== {1'b1, 2'b10, 32'h0}) begin
      $display("[TB] FAIL nomatch_slverr: valid=%b status=%b data=%h expected 1 10 00000000",
               a_resp_valid, a_status, a_read_data);
      n_mismatched++;
    end
    consume_response();
    // Instance b uses ERROR_STATUS=0, so the same case reports OKAY with zero data.
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    n_compared++;
    if ({b_register_valid, b_host_ready} !== 2'b10) begin
      $display("[TB] FAIL nomatch_b_busy: got %b expected 10", {b_register_valid, b_host_ready});
      n_mismatched++;
    end
    tick();
    n_compared++;
    if ({b_resp_valid, b_status, b_read_data} !== {1'b1, 2'b00, 32'h0}) begin
      $display("[TB] FAIL nomatch_okay: valid=%b status=%b data=%h expected 1 00 00000000",
               b_resp_valid, b_status, b_read_data);
      n_mismatched++;
    end
    b_resp_ready = 1'b1;
    tick();
    b_resp_ready = 1'b0;
    n_compared++;
    if ({b_resp_valid, b_host_ready} !== 2'b01) begin
      $display("[TB] FAIL nomatch_b_release: got %b expected 01", {b_resp_valid, b_host_ready});
      n_mismatched++;
    end
  endtask

  task automatic test_timeout();
    a_active = 2'b01; a_ready = 2'b00; a_reg_read_data = {32'h0, 32'h5555_5555};
    start_request(2'b00, 8'h20, 32'h0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      n_compared++;
      if ({a_register_valid, a_resp_valid} !== 2'b10) begin
        $display("[TB] FAIL timeout_busy_%0d: got %b expected 10", k, {a_register_valid, a_resp_valid});
        n_mismatched++;
      end
      tick();
    end
    n_compared++;
    if ({a_register_valid, a_resp_valid, a_status, a_read_data} !== {1'b0, 1'b1, 2'b11, 32'h0}) begin
      $display("[TB] FAIL timeout_response: regvalid=%b valid=%b status=%b data=%h expected 0 1 11 00000000",
               a_register_valid, a_resp_valid, a_status, a_read_data);
      n_mismatched++;
    end
    consume_response();
  endtask

  task automatic test_resp_hold();
    a_active = 2'b01; a_ready = 2'b01;
    a_reg_status = 4'b00_00; a_reg_read_data = {32'h0, 32'h0BAD_F00D};
    start_request(2'b00, 8'h08, 32'h0, 32'h0);
    // A second request waits while the first response is still pending.
    host_valid = 1'b1; host_address = 8'h0C;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_compared++;
      if ({a_resp_valid, a_status, a_read_data, a_host_ready, a_register_valid}
          !== {1'b1, 2'b00, 32'h0BAD_F00D, 1'b0, 1'b0}) begin
        $display("[TB] FAIL hold_%0d: valid=%b status=%b data=%h ready=%b regvalid=%b expected 1 00 0badf00d 0 0",
                 k, a_resp_valid, a_status, a_read_data, a_host_ready, a_register_valid);
        n_mismatched++;
      end
      tick();
    end
    host_resp_ready = 1'b1;
    n_compared++;
    if (a_host_ready !== 1'b0) begin
      $display("[TB] FAIL hold_ready_same_cycle: got %b expected 0", a_host_ready);
      n_mismatched++;
    end
    tick();
    host_resp_ready = 1'b0;
    n_compared++;
    if ({a_resp_valid, a_host_ready} !== 2'b01) begin
      $display("[TB] FAIL hold_release: got %b expected 01", {a_resp_valid, a_host_ready});
      n_mismatched++;
    end
    tick();
    host_valid = 1'b0;
    n_compared++;
    if ({a_register_valid, a_register_address} !== {1'b1, 8'h0C}) begin
      $display("[TB] FAIL hold_next_accept: regvalid=%b addr=%h expected 1 0c",
               a_register_valid, a_register_address);
      n_mismatched++;
    end
    tick();
    consume_response();
  endtask

  task automatic test_reset_mid();
    a_active = 2'b01; a_ready = 2'b00;
    start_request(2'b00, 8'h30, 32'h0, 32'h0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_compared++;
    if ({a_register_valid, a_resp_valid, a_host_ready, a_register_address} !== {3'b001, 8'h00}) begin
      $display("[TB] FAIL async_reset: regvalid=%b valid=%b ready=%b addr=%h expected 0 0 1 00",
               a_register_valid, a_resp_valid, a_host_ready, a_register_address);
      n_mismatched++;
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_compared++;
      if ({a_resp_valid, a_register_valid} !== 2'b00) begin
        $display("[TB] FAIL reset_no_response_%0d: got %b expected 00", k, {a_resp_valid, a_register_valid});
        n_mismatched++;
      end
    end
    a_ready = 2'b01; a_reg_read_data = {32'h0, 32'h600D_0002};
    start_request(2'b00, 8'h34, 32'h0, 32'h0);
    tick();
    n_compared++;
    if ({a_resp_valid, a_status, a_read_data} !== {1'b1, 2'b00, 32'h600D_0002}) begin
      $display("[TB] FAIL after_reset_read: valid=%b status=%b data=%h expected 1 00 600d0002",
               a_resp_valid, a_status, a_read_data);
      n_mismatched++;
    end
    consume_response();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_no_match();
    test_timeout();
    test_resp_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
